// File: rtl/mul_share_arb_if.sv
// Requester and result channel bundle for mul_share_arb.
// The slave side is the arbiter; the master side is the requesters plus the result consumer.
interface mul_share_arb_if;
   logic       req0;
   logic [3:0] a0;
   logic [3:0] b0;
   logic       gnt0;
   logic       req1;
   logic [3:0] a1;
   logic [3:0] b1;
   logic       gnt1;
   logic       res_valid;
   logic [7:0] res_prod;
   logic       res_id;
   logic       res_ready;
   logic       busy;

   modport slave (
      input  req0, a0, b0, req1, a1, b1, res_ready,
      output gnt0, gnt1, res_valid, res_prod, res_id, busy
   );

   modport master (
      output req0, a0, b0, req1, a1, b1, res_ready,
      input  gnt0, gnt1, res_valid, res_prod, res_id, busy
   );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin arbiter that shares one combinational 4x4 multiplier between two requesters.
// The registered, ID-tagged product is held on a valid/ready channel until it is accepted.

module Mul (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] carry,
   output logic [3:0] sum
);
   assign {carry, sum} = 8'(a) * 8'(b);
endmodule

module mul_share_arb #(
   parameter int unsigned MUL_LAT = 1
) (
   input logic            clk,
   input logic            rst,
   mul_share_arb_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

   state_t     state, state_nxt;
   logic [3:0] op_a, op_a_nxt;
   logic [3:0] op_b, op_b_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       last, last_nxt;
   logic       gnt0, gnt0_nxt;
   logic       gnt1, gnt1_nxt;
   logic       res_valid, res_valid_nxt;
   logic [7:0] res_prod, res_prod_nxt;
   logic       res_id, res_id_nxt;
   logic       win;
   logic [3:0] carry;
   logic [3:0] sum;

   Mul u_mul (
      .a     (op_a),
      .b     (op_b),
      .carry (carry),
      .sum   (sum)
   );

   // Sole requester wins; on a tie the one that was not served last wins.
   assign win = (bus.req0 & bus.req1) ? ~last : bus.req1;

   always_comb begin
      state_nxt     = state;
      op_a_nxt      = op_a;
      op_b_nxt      = op_b;
      cnt_nxt       = cnt;
      last_nxt      = last;
      gnt0_nxt      = 1'b0;
      gnt1_nxt      = 1'b0;
      res_valid_nxt = res_valid;
      res_prod_nxt  = res_prod;
      res_id_nxt    = res_id;
      case (state)
         IDLE: begin
            if (bus.req0 | bus.req1) begin
               op_a_nxt  = win ? bus.a1 : bus.a0;
               op_b_nxt  = win ? bus.b1 : bus.b0;
               last_nxt  = win;
               gnt0_nxt  = ~win;
               gnt1_nxt  = win;
               cnt_nxt   = CNT_INIT;
               state_nxt = CALC;
            end
         end
         CALC: begin
            if (cnt == '0) begin
               res_prod_nxt  = {carry, sum};
               res_id_nxt    = last;
               res_valid_nxt = 1'b1;
               state_nxt     = DONE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         DONE: begin
            if (res_valid & bus.res_ready) begin
               res_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         cnt       <= '0;
         last      <= 1'b1;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         res_valid <= 1'b0;
         res_prod  <= '0;
         res_id    <= 1'b0;
      end else begin
         state     <= state_nxt;
         op_a      <= op_a_nxt;
         op_b      <= op_b_nxt;
         cnt       <= cnt_nxt;
         last      <= last_nxt;
         gnt0      <= gnt0_nxt;
         gnt1      <= gnt1_nxt;
         res_valid <= res_valid_nxt;
         res_prod  <= res_prod_nxt;
         res_id    <= res_id_nxt;
      end
   end

   assign bus.gnt0      = gnt0;
   assign bus.gnt1      = gnt1;
   assign bus.res_valid = res_valid;
   assign bus.res_prod  = res_prod;
   assign bus.res_id    = res_id;
   assign bus.busy      = (state != IDLE);
endmodule
